tx_buffer: RTL and testbench

Store-and-forward flit FIFO that holds outgoing packets for one transmit channel and presents them to the tx buffer selecter. It accepts flits from the packet builder with a valid/ready handshake, counts complete packets, and exposes a head flit only once a full packet (head through tail) is resident, so the selecter never starves mid-packet. It is the stage directly upstream of the selecter; one instance exists per tx channel.

---
 rtl/tx_buffer_if.sv | 24 ++
 rtl/tx_buffer.sv | 117 +++++++++++
 tb/tb_tx_buffer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/tx_buffer_if.sv
// Flit stream bundle between the packet builder, tx_buffer and the tx buffer selecter.
// The slave view belongs to tx_buffer; the master view drives it.
interface tx_buffer_if #(
    parameter int FLIT_WIDTH = 64
);
    logic [FLIT_WIDTH-1:0] in_flit;
    logic                  in_is_tail;
    logic                  in_valid;
    logic                  in_ready;
    logic [FLIT_WIDTH-1:0] out_flit;
    logic                  out_is_tail;
    logic                  out_valid;
    logic                  out_ready;

    modport slave (
        input  in_flit, in_is_tail, in_valid, out_ready,
        output in_ready, out_flit, out_is_tail, out_valid
    );

    modport master (
        output in_flit, in_is_tail, in_valid, out_ready,
        input  in_ready, out_flit, out_is_tail, out_valid
    );
endinterface

// File: rtl/tx_buffer.sv
// Store-and-forward flit FIFO for one tx channel. A head flit is offered only while at
// least one complete packet is resident. A packet too long for the buffer is flushed and dropped.
module tx_buffer #(
    parameter  int FLIT_WIDTH = 64,
    parameter  int DEPTH      = 8,
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    tx_buffer_if.slave       bus,
    output logic [CNT_W-1:0] flit_count,
    output logic [CNT_W-1:0] packet_count,
    output logic             overflow_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [0:0] {IDLE, DROP} state_e;

    state_e           state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] flit_cnt_q, flit_cnt_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic             ovf_q, ovf_d;
    logic             full, push, pop, wr_en;

    // Each entry is {is_tail, flit}.
    logic [FLIT_WIDTH:0] mem_q [DEPTH];

    assign full          = (flit_cnt_q == FULL_CNT);
    assign bus.in_ready  = ~rst & ~full;
    assign bus.out_valid = (pkt_cnt_q != '0);
    assign bus.out_flit    = mem_q[rd_ptr_q][FLIT_WIDTH-1:0];
    assign bus.out_is_tail = mem_q[rd_ptr_q][FLIT_WIDTH];
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;

    assign flit_count   = flit_cnt_q;
    assign packet_count = pkt_cnt_q;
    assign overflow_err = ovf_q;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        flit_cnt_d = flit_cnt_q;
        pkt_cnt_d  = pkt_cnt_q;
        ovf_d      = ovf_q;
        wr_en      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (full && pkt_cnt_q == '0) begin
                    // Full with no tail in sight: flush and swallow the rest of this packet.
                    state_d    = DROP;
                    ovf_d      = 1'b1;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    flit_cnt_d = '0;
                    pkt_cnt_d  = '0;
                end else begin
                    if (push) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    end
                    if (pop) begin
                        rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    end
                    unique case ({push, pop})
                        2'b10:   flit_cnt_d = flit_cnt_q + CNT_W'(1);
                        2'b01:   flit_cnt_d = flit_cnt_q - CNT_W'(1);
                        default: flit_cnt_d = flit_cnt_q;
                    endcase
                    unique case ({push & bus.in_is_tail, pop & bus.out_is_tail})
                        2'b10:   pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
                        2'b01:   pkt_cnt_d = pkt_cnt_q - CNT_W'(1);
                        default: pkt_cnt_d = pkt_cnt_q;
                    endcase
                end
            end
            DROP: begin
                if (push && bus.in_is_tail) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            flit_cnt_q <= '0;
            pkt_cnt_q  <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            flit_cnt_q <= flit_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    // NOTE: storage is not reset; entries are only read once counters mark them as written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {bus.in_is_tail, bus.in_flit};
        end
    end
endmodule

// File: tb/tb_tx_buffer.sv
// Directed bench for tx_buffer (FLIT_WIDTH 64, DEPTH 8): inputs change on the falling edge,
// outputs are compared 1 ns later.
module tb_tx_buffer;
    logic       clk;
    logic       rst;
    logic [3:0] flit_count;
    logic [3:0] packet_count;
    logic       overflow_err;
    int         checks = 0;
    int         errors = 0;

    tx_buffer_if #(.FLIT_WIDTH(64)) bus ();

    tx_buffer #(.FLIT_WIDTH(64), .DEPTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .flit_count   (flit_count),
        .packet_count (packet_count),
        .overflow_err (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [63:0] f, input logic t, input logic r);
        bus.in_valid   = v;
        bus.in_flit    = f;
        bus.in_is_tail = t;
        bus.out_ready  = r;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 64'h0, 1'b0, 1'b0);

        // Reset state
        tick();
        tick();
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_flit_count", flit_count, 4'd0);
        check("rst_packet_count", packet_count, 4'd0);
        check("rst_overflow", overflow_err, 1'b0);
        rst = 1'b0;
        #1;
        check("release_in_ready", bus.in_ready, 1'b1);

        // Store-and-forward: 3-flit packet
        drive(1'b1, 64'h101, 1'b0, 1'b0);
        tick();
        check("sf_valid_1", bus.out_valid, 1'b0);
        check("sf_count_1", flit_count, 4'd1);
        drive(1'b1, 64'h102, 1'b0, 1'b0);
        tick();
        check("sf_valid_2", bus.out_valid, 1'b0);
        drive(1'b1, 64'h103, 1'b1, 1'b0);
        check("sf_valid_tail_cycle", bus.out_valid, 1'b0);
        tick();
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        check("sf_valid_after_tail", bus.out_valid, 1'b1);
        check("sf_pkt_count", packet_count, 4'd1);
        check("sf_flit_count", flit_count, 4'd3);
        check("sf_head_flit", bus.out_flit, 64'h101);
        check("sf_head_tail", bus.out_is_tail, 1'b0);
        drive(1'b0, 64'h0, 1'b0, 1'b1);
        tick();
        check("sf_flit2", bus.out_flit, 64'h102);
        check("sf_flit2_tail", bus.out_is_tail, 1'b0);
        tick();
        check("sf_flit3", bus.out_flit, 64'h103);
        check("sf_flit3_tail", bus.out_is_tail, 1'b1);
        tick();
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        check("sf_drained_valid", bus.out_valid, 1'b0);
        check("sf_drained_count", flit_count, 4'd0);

        // Full buffer, no bypass
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 64'h10 + 64'(i), 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        check("full_in_ready", bus.in_ready, 1'b0);
        check("full_pkt_count", packet_count, 4'd8);
        check("full_flit_count", flit_count, 4'd8);
        check("full_head", bus.out_flit, 64'h10);
        drive(1'b1, 64'h55, 1'b1, 1'b1);
        check("full_no_bypass_ready", bus.in_ready, 1'b0);
        tick();
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        check("full_pop_only_count", flit_count, 4'd7);
        check("full_pop_only_pkts", packet_count, 4'd7);
        check("full_ready_again", bus.in_ready, 1'b1);
        drive(1'b0, 64'h0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("full_drain_%0d", i), bus.out_flit, 64'h11 + 64'(i));
            tick();
        end
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        check("full_drained_valid", bus.out_valid, 1'b0);
        check("full_drained_count", flit_count, 4'd0);

        // Wrap-around streaming: push and pop together every cycle
        for (int i = 0; i <= 20; i++) begin
            if (i < 20) drive(1'b1, 64'hA0 + 64'(i), 1'b1, 1'b1);
            else        drive(1'b0, 64'h0, 1'b0, 1'b1);
            check($sformatf("wrap_count_%0d", i), flit_count, (i == 0) ? 4'd0 : 4'd1);
            if (i > 0) begin
                check($sformatf("wrap_valid_%0d", i), bus.out_valid, 1'b1);
                check($sformatf("wrap_flit_%0d", i), bus.out_flit, 64'hA0 + 64'(i - 1));
            end
            tick();
        end
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        check("wrap_end_valid", bus.out_valid, 1'b0);
        check("wrap_end_count", flit_count, 4'd0);

        // Oversize packet
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 64'hB0 + 64'(i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        check("ovf_detect_ready", bus.in_ready, 1'b0);
        check("ovf_detect_count", flit_count, 4'd8);
        check("ovf_detect_err", overflow_err, 1'b0);
        tick();
        check("ovf_err_set", overflow_err, 1'b1);
        check("ovf_flushed", flit_count, 4'd0);
        check("ovf_ready", bus.in_ready, 1'b1);
        check("ovf_valid", bus.out_valid, 1'b0);
        drive(1'b1, 64'hC0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 64'hC1, 1'b0, 1'b0);
        tick();
        check("drop_count", flit_count, 4'd0);
        drive(1'b1, 64'hC2, 1'b1, 1'b0);
        check("drop_tail_ready", bus.in_ready, 1'b1);
        tick();
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        check("drop_tail_count", flit_count, 4'd0);
        check("drop_tail_valid", bus.out_valid, 1'b0);
        drive(1'b1, 64'hD0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 64'hD1, 1'b1, 1'b0);
        tick();
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        check("post_ovf_valid", bus.out_valid, 1'b1);
        check("post_ovf_pkts", packet_count, 4'd1);
        check("post_ovf_count", flit_count, 4'd2);
        check("post_ovf_head", bus.out_flit, 64'hD0);
        drive(1'b0, 64'h0, 1'b0, 1'b1);
        tick();
        check("post_ovf_flit2", bus.out_flit, 64'hD1);
        check("post_ovf_flit2_tail", bus.out_is_tail, 1'b1);
        tick();
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        check("post_ovf_empty", bus.out_valid, 1'b0);
        check("post_ovf_sticky", overflow_err, 1'b1);

        // Reset mid-operation
        drive(1'b1, 64'hE0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 64'hE1, 1'b1, 1'b0);
        tick();
        drive(1'b0, 64'h0, 1'b0, 1'b1);
        check("mid_pkts_before", packet_count, 4'd2);
        rst = 1'b1;
        #1;
        check("mid_rst_count", flit_count, 4'd0);
        check("mid_rst_pkts", packet_count, 4'd0);
        check("mid_rst_valid", bus.out_valid, 1'b0);
        check("mid_rst_ready", bus.in_ready, 1'b0);
        check("mid_rst_ovf", overflow_err, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        check("mid_release_ready", bus.in_ready, 1'b1);
        check("mid_release_valid", bus.out_valid, 1'b0);
        tick();
        check("mid_no_stale_valid", bus.out_valid, 1'b0);
        check("mid_no_stale_count", flit_count, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
